// File: rtl/obstacle_render_pkg.sv
// Shared definitions for the obstacle pixel renderer.
//   - hash geometry used to derive a wall style from the obstacle's absolute y
//   - reset contents of the runtime-writable palette
//   - pattern_color(): contents of the wall pattern ROM, indexed by
//     (style, row, column) inside a tile; returns a colour index
package obstacle_render_pkg;

    localparam int HASH_SLICE_W = 3;
    localparam int HASH_SLICE_N = 5;
    localparam int HASH_W       = HASH_SLICE_W * HASH_SLICE_N;

    // Width of a colour index as stored in the pattern ROM (palettes are at most 16 entries).
    localparam int COLOR_W = 4;

    localparam logic [11:0] PAL_DEFAULT_0 = 12'h5B0;
    localparam logic [11:0] PAL_DEFAULT_1 = 12'h000;
    localparam logic [11:0] PAL_DEFAULT_2 = 12'h777;
    localparam logic [11:0] PAL_DEFAULT_3 = 12'hAAA;

    function automatic logic [11:0] default_color(input int idx);
        logic [11:0] c;
        case (idx)
            0:       c = PAL_DEFAULT_0;
            1:       c = PAL_DEFAULT_1;
            2:       c = PAL_DEFAULT_2;
            3:       c = PAL_DEFAULT_3;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    // Four base patterns; styles above 3 reuse them with a shifted colour index.
    function automatic logic [COLOR_W-1:0] pattern_color(input int style, input int y, input int x);
        int v;
        case (style % 4)
            0:       v = ((y % 4) == 0 || x == 0) ? 2 : 3;      // bricks with mortar lines
            1:       v = (x + y) % 4;                           // diagonal stripes
            2:       v = (x == y || x + y == 9) ? 3 : 1;        // cross-hatch
            default: v = (y * 3 + x) % 4;                       // steep stripes
        endcase
        v = v + style / 4;
        return COLOR_W'(v);
    endfunction

endpackage

// File: rtl/obstacle_render_pipeline_rom.sv
// Wall pattern ROM with a registered (one-cycle) read.
// Contents come from obstacle_render_pkg::pattern_color; rows at or beyond the
// tile width read as colour index 0.
// Ports:
//   clk        read clock
//   style      wall style
//   y          row inside the tile (unclamped)
//   x          column inside the tile (already mirrored if needed)
//   color_idx  colour index, valid one cycle after the address
module obstacle_pattern_rom
    import obstacle_render_pkg::*;
#(
    parameter int STYLE_W        = 2,
    parameter int Y_W            = 9,
    parameter int X_W            = 4,
    parameter int OBSTACLE_WIDTH = 10
) (
    input  logic               clk,
    input  logic [STYLE_W-1:0] style,
    input  logic [Y_W-1:0]     y,
    input  logic [X_W-1:0]     x,
    output logic [COLOR_W-1:0] color_idx
);

    always_ff @(posedge clk) begin
        if (int'(y) < OBSTACLE_WIDTH) begin
            color_idx <= pattern_color(int'(style), int'(y), int'(x));
        end else begin
            color_idx <= '0;
        end
    end

endmodule

// File: rtl/obstacle_render_pipeline.sv
// Obstacle pixel renderer: three register stages from pixel coordinates to RGB.
//   S1  style/mirror/row selection from absolute position and tile offsets
//   S2  pattern ROM read -> colour index
//   S3  palette lookup (with animation offset) -> rgb
// Optional feature macro: OBSTACLE_RENDER_ANIM_EN enables frame-synchronous
// palette animation; without it anim_offset is 0 and frame_start is ignored.
// Ports:
//   sys_clk, sys_rst                pixel clock, asynchronous active-high reset
//   pix_valid                       input pixel qualifier
//   obstacle_x_rom, obstacle_y_rom  offsets inside the obstacle run / tile
//   obstacle_block_abs_y            block absolute y
//   obstacle_abs_pos_x/_y           obstacle absolute position
//   obstacle_on                     pixel lies inside an obstacle
//   frame_start                     one-cycle pulse at frame start
//   pal_we, pal_addr, pal_data      palette write port
//   rgb, rgb_valid, style_id        registered pixel output
// Handshake: no backpressure. pix_valid marks a pixel on the cycle it is
// presented; rgb_valid marks the matching output exactly three clock edges
// later. Bubbles produce rgb_valid=0 with rgb=0 and style_id=0.
module obstacle_render_pipeline
    import obstacle_render_pkg::*;
#(
    parameter int STYLE_NUM      = 4,
    parameter int PALETTE_NUM    = 4,
    parameter int OBSTACLE_WIDTH = 10,
    parameter int SCREEN_WIDTH   = 10,
    parameter int PHY_WIDTH      = 14,
    parameter int PIXEL_WIDTH    = 12,
    parameter int ANIM_PERIOD    = 8
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic                           pix_valid,
    input  logic [SCREEN_WIDTH-1:0]        obstacle_x_rom,
    input  logic [SCREEN_WIDTH-1:0]        obstacle_y_rom,
    input  logic [PHY_WIDTH-1:0]           obstacle_block_abs_y,
    input  logic [PHY_WIDTH-1:0]           obstacle_abs_pos_x,
    input  logic [PHY_WIDTH-1:0]           obstacle_abs_pos_y,
    input  logic                           obstacle_on,
    input  logic                           frame_start,
    input  logic                           pal_we,
    input  logic [$clog2(PALETTE_NUM)-1:0] pal_addr,
    input  logic [PIXEL_WIDTH-1:0]         pal_data,
    output logic [PIXEL_WIDTH-1:0]         rgb,
    output logic                           rgb_valid,
    output logic [$clog2(STYLE_NUM)-1:0]   style_id
);

    localparam int STYLE_W = $clog2(STYLE_NUM);
    localparam int PAL_W   = $clog2(PALETTE_NUM);
    localparam int X_W     = $clog2(OBSTACLE_WIDTH);
    localparam int Y_W     = SCREEN_WIDTH - 1;
    localparam logic [SCREEN_WIDTH-1:0] OW_S = SCREEN_WIDTH'(OBSTACLE_WIDTH);

    // ---------------- S1: style / mirror / row selection ----------------
    logic [SCREEN_WIDTH-1:0] tile_base;
    logic [SCREEN_WIDTH-1:0] x_in_tile;
    logic [SCREEN_WIDTH-1:0] lx_full;
    logic [PHY_WIDTH-1:0]    block_x;
    logic [HASH_W-1:0]       y_pad;
    logic [HASH_SLICE_W-1:0] hash;
    logic                    is_random;
    logic                    face;
    logic [STYLE_W-1:0]      style_d;

    always_comb begin
        tile_base = (obstacle_x_rom / OW_S) * OW_S;
        x_in_tile = obstacle_x_rom - tile_base;
        block_x   = {obstacle_abs_pos_x[PHY_WIDTH-2:0], 1'b0} + obstacle_block_abs_y
                  + PHY_WIDTH'(tile_base) - PHY_WIDTH'(7);
        is_random = (&block_x[4:3]) & (|block_x[1:0]);
        // Absolute y is zero-padded to a whole number of hash slices.
        y_pad = HASH_W'(obstacle_abs_pos_y);
        hash  = '0;
        for (int i = 0; i < HASH_SLICE_N; i++) begin
            hash = hash ^ y_pad[i*HASH_SLICE_W +: HASH_SLICE_W];
        end
        face    = is_random | (hash[1] ^ hash[0]);
        style_d = is_random ? block_x[STYLE_W-1:0] : STYLE_W'(hash);
        // face=0 walls are drawn mirrored horizontally inside the tile.
        lx_full = face ? x_in_tile : (OW_S - SCREEN_WIDTH'(1) - x_in_tile);
    end

    logic               v1;
    logic               on1;
    logic [STYLE_W-1:0] style1;
    logic [X_W-1:0]     lx1;
    logic [Y_W-1:0]     ry1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) v1 <= 1'b0;
        else         v1 <= pix_valid;
    end

    // Data stages carry no reset: the valid bits mask them at the output.
    always_ff @(posedge sys_clk) begin
        if (pix_valid) begin
            on1    <= obstacle_on;
            style1 <= style_d;
            lx1    <= X_W'(lx_full);
            ry1    <= obstacle_y_rom[SCREEN_WIDTH-1:1];
        end
    end

    // ---------------- S2: pattern ROM read ----------------
    logic               v2;
    logic               on2;
    logic [STYLE_W-1:0] style2;
    logic [COLOR_W-1:0] idx2;

    obstacle_pattern_rom #(
        .STYLE_W        (STYLE_W),
        .Y_W            (Y_W),
        .X_W            (X_W),
        .OBSTACLE_WIDTH (OBSTACLE_WIDTH)
    ) u_rom (
        .clk       (sys_clk),
        .style     (style1),
        .y         (ry1),
        .x         (lx1),
        .color_idx (idx2)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) v2 <= 1'b0;
        else         v2 <= v1;
    end

    always_ff @(posedge sys_clk) begin
        on2    <= on1;
        style2 <= style1;
    end

    // ---------------- Animation offset ----------------
    // anim_eff is the offset S3 uses this cycle; on a frame_start cycle it is
    // already the updated value, so the pixel in S3 sees the new offset.
    logic [PAL_W-1:0] anim_eff;

`ifdef OBSTACLE_RENDER_ANIM_EN
    localparam int FC_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

    logic [FC_W-1:0]  frame_cnt;
    logic [PAL_W-1:0] anim_offset;
    logic             frame_wrap;

    assign frame_wrap = (frame_cnt == FC_W'(ANIM_PERIOD - 1));
    assign anim_eff   = (frame_start && frame_wrap) ? anim_offset + PAL_W'(1) : anim_offset;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_cnt   <= '0;
            anim_offset <= '0;
        end else if (frame_start) begin
            frame_cnt   <= frame_wrap ? '0 : frame_cnt + FC_W'(1);
            anim_offset <= anim_eff;
        end
    end
`else
    assign anim_eff = '0;
`endif

    // ---------------- Palette ----------------
    // Write lands at the clock edge, so a same-cycle S3 read sees the old entry.
    logic [PIXEL_WIDTH-1:0] palette [PALETTE_NUM];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < PALETTE_NUM; i++) begin
                palette[i] <= PIXEL_WIDTH'(default_color(i));
            end
        end else if (pal_we) begin
            palette[pal_addr] <= pal_data;
        end
    end

    // ---------------- S3: palette lookup ----------------
    logic [PAL_W-1:0] pal_idx;
    assign pal_idx = PAL_W'(idx2) + anim_eff;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rgb       <= '0;
            rgb_valid <= 1'b0;
            style_id  <= '0;
        end else begin
            rgb_valid <= v2;
            style_id  <= v2 ? style2 : '0;
            rgb       <= (v2 && on2) ? palette[pal_idx] : '0;
        end
    end

endmodule

// File: doc/obstacle_render_pipeline.md
# obstacle_render_pipeline

Next-generation obstacle pixel renderer. It takes per-pixel obstacle coordinates from the scan/scroll logic and produces a registered RGB pixel with a fixed 3-cycle latency. It supports a parametrised number of wall styles and palette entries, a runtime-writable palette, and optional frame-synchronous palette animation. It sits between the obstacle position/scroll logic and the VGA pixel mux.

## Interface
- STYLE_NUM, 4, number of wall pattern styles (power of two, 2..16)
- PALETTE_NUM, 4, palette entries (power of two, 2..16)
- OBSTACLE_WIDTH, 10, obstacle tile width in pixels; tile height = 2*OBSTACLE_WIDTH
- SCREEN_WIDTH, 10, width of rom coordinate inputs
- PHY_WIDTH, 14, width of absolute position inputs
- PIXEL_WIDTH, 12, RGB width
- ANIM_PERIOD, 8, frames per animation step (>=1)

Ports:
- sys_clk  in  1  pixel clock
- sys_rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  input pixel qualifier
- obstacle_x_rom  in  SCREEN_WIDTH  x offset inside obstacle run
- obstacle_y_rom  in  SCREEN_WIDTH  y offset inside tile
- obstacle_block_abs_y  in  PHY_WIDTH  block absolute y
- obstacle_abs_pos_x  in  PHY_WIDTH  obstacle absolute x
- obstacle_abs_pos_y  in  PHY_WIDTH  obstacle absolute y
- obstacle_on  in  1  pixel lies inside an obstacle
- frame_start  in  1  one-cycle pulse at start of each frame
- pal_we  in  1  palette write strobe
- pal_addr  in  $clog2(PALETTE_NUM)  palette write index
- pal_data  in  PIXEL_WIDTH  palette write data
- rgb  out  PIXEL_WIDTH  pixel colour
- rgb_valid  out  1  rgb qualifier
- style_id  out  $clog2(STYLE_NUM)  selected style, aligned with rgb

## Operation
- S1, captured on pix_valid. Compute:
  - block_x = (abs_pos_x<<1) + block_abs_y + OBSTACLE_WIDTH*(x_rom/OBSTACLE_WIDTH) - 7, mod 2^PHY_WIDTH.
  - random = &block_x[4:3] & |block_x[1:0].
  - hash = XOR of the five 3-bit slices of {1'b0, abs_pos_y} (zero-padded to 15 bits).
  - style = random ? block_x mod STYLE_NUM : hash mod STYLE_NUM.
  - face = random | (hash[1]^hash[0]).
  - local_x = x_rom mod OBSTACLE_WIDTH; if face=0, local_x = OBSTACLE_WIDTH-1-local_x (mirror).
  - rom_y = y_rom>>1. The value is not clamped; rom_y >= OBSTACLE_WIDTH reads colour index 0.
- S2: synchronous pattern ROM read at {style, rom_y, local_x} gives a colour index.
- S3: rgb = obstacle_on ? palette[(colour_idx + anim_offset) mod PALETTE_NUM] : 0.
- The pipeline never stalls. Bubbles (pix_valid=0) propagate as rgb_valid=0, and rgb is forced to 0 for them.
- Palette:
  - Reset contents are 12'h5B0, 12'h000, 12'h777, 12'hAAA for entries 0..3. Entries 4 and up reset to 0.
  - pal_we writes on the clock edge.
  - An S3 read of the same entry in the same cycle returns the old value.
- Reset: rgb, rgb_valid, style_id, pipeline valids, frame counter and anim_offset all go to 0, and the palette returns to its defaults. In-flight pixels are discarded. Reset asserted mid-line yields rgb_valid=0 until 3 cycles after the first post-reset pix_valid.

## Timing
- Latency is 3 cycles: pix_valid at edge N gives rgb_valid/rgb/style_id at edge N+3.
- Throughput is 1 pixel/cycle.
- anim_offset changes only on the frame_start cycle, so there is no mid-frame colour change. Pixels already in S3 on that cycle use the new offset.
- frame_start and pal_we in the same cycle are independent and both take effect.

## Configuration
- OBSTACLE_RENDER_ANIM_EN defined:
  - Frame counter 0..ANIM_PERIOD-1 increments on each frame_start.
  - On wrap, anim_offset increments mod PALETTE_NUM.
- OBSTACLE_RENDER_ANIM_EN undefined: the counter is absent, anim_offset is constant 0, and frame_start is ignored.

## Structure
- Shared package obstacle_render_pkg holds:
  - the hash slice width (3) and slice count (5);
  - the default palette constants;
  - the pattern ROM contents function pattern_color(style, y, x), also used by the bench as its reference model.
- Sub-module obstacle_pattern_rom: synchronous-read ROM with one-cycle latency, initialised from the package and inferred as block RAM.

## Test plan
- Non-random hash path: abs_pos_y=5, abs_pos_x=0, block_abs_y=7, x_rom=0, pix_valid at N -> at N+3 rgb_valid=1, style_id=1, face=1 (no mirror), rgb = palette[pattern_color(1, y>>1, 0)].
- Mirroring: abs_pos_y=3 (hash=3, face=0), x_rom=2 -> ROM is read at local_x=7.
- Random path: abs_pos_x=0, block_abs_y=34, x_rom=0 (block_x=27) -> style_id=3, no mirror.
- Palette write: pal_we with addr 2, data 12'hF00; next a pixel whose colour index is 2 -> rgb=12'hF00. A same-cycle read of entry 2 -> 12'h777. obstacle_on=0 -> rgb=0.
- Streaming and reset: 100 back-to-back pixels -> 100 consecutive rgb_valid, starting 3 cycles after the first. sys_rst asserted mid-stream -> rgb_valid=0 immediately and the palette returns to its defaults.
- Animation, ANIM_PERIOD=2, OBSTACLE_RENDER_ANIM_EN defined: after 2 frame_start pulses, colour index 0 -> 12'h000. After 8 pulses the offset wraps back to 0. With the macro undefined, rgb is unchanged by any frame_start.
